// File: rtl/mvb_rr_merge.sv
// Round-robin merger: packs granted single-item MVB inputs into one ITEMS-wide registered MVB word.
// Optional accepted-word/item counters are compiled in when MVB_RR_MERGE_STATS_EN is defined.
module mvb_rr_merge #(
    parameter int PORTS      = 8,
    parameter int ITEMS      = 4,
    parameter int ITEM_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [PORTS*ITEM_WIDTH-1:0] rx_data,
    input  logic [PORTS-1:0]            rx_vld,
    input  logic [PORTS-1:0]            rx_src_rdy,
    output logic [PORTS-1:0]            rx_dst_rdy,
    output logic [ITEMS*ITEM_WIDTH-1:0] tx_data,
    output logic [ITEMS-1:0]            tx_vld,
    output logic                        tx_src_rdy,
    input  logic                        tx_dst_rdy,
    output logic [31:0]                 stat_words,
    output logic [31:0]                 stat_items
);

    localparam int PW = $clog2(PORTS);

    logic [PW-1:0]               ptr;
    logic [PW-1:0]               nxt_ptr;
    logic [PW:0]                 ptr_sum;
    logic                        adv;
    logic [PORTS-1:0]            req;
    logic [PORTS-1:0]            rot_req;
    logic [PORTS-1:0]            rot_grant;
    logic [PORTS-1:0]            grant;
    logic [PORTS*ITEM_WIDTH-1:0] rot_data;
    logic [ITEMS*ITEM_WIDTH-1:0] nxt_data;
    logic [ITEMS-1:0]            nxt_vld;
    int                          n;
    int                          last_i;

    // Inputs are rotated so the scan always starts at bit 0; grants are rotated back afterwards.
    always_comb begin
        req       = rx_src_rdy & rx_vld;
        adv       = !tx_src_rdy || tx_dst_rdy;
        rot_req   = (req >> ptr) | (req << (PORTS - int'(ptr)));
        rot_data  = (rx_data >> (int'(ptr) * ITEM_WIDTH))
                  | (rx_data << ((PORTS - int'(ptr)) * ITEM_WIDTH));
        rot_grant = '0;
        nxt_data  = '0;
        nxt_vld   = '0;
        n         = 0;
        last_i    = 0;
        if (adv) begin
            for (int i = 0; i < PORTS; i++) begin
                if (rot_req[i] && n < ITEMS) begin
                    rot_grant[i] = 1'b1;
                    for (int k = 0; k < ITEMS; k++) begin
                        if (k == n) begin
                            nxt_data[k*ITEM_WIDTH +: ITEM_WIDTH] = rot_data[i*ITEM_WIDTH +: ITEM_WIDTH];
                        end
                    end
                    n      = n + 1;
                    last_i = i;
                end
            end
        end
        for (int k = 0; k < ITEMS; k++) begin
            nxt_vld[k] = (k < n);
        end
        grant   = (rot_grant << ptr) | (rot_grant >> (PORTS - int'(ptr)));
        ptr_sum = {1'b0, ptr} + (PW+1)'(last_i) + (PW+1)'(1);
        nxt_ptr = (ptr_sum >= (PW+1)'(PORTS)) ? PW'(ptr_sum - (PW+1)'(PORTS)) : PW'(ptr_sum);
    end

    // Empty words (src_rdy without vld) are simply acknowledged whenever the output can advance.
    assign rx_dst_rdy = reset ? ((grant | (rx_src_rdy & ~rx_vld)) & {PORTS{adv}}) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_src_rdy <= 1'b0;
            tx_vld     <= '0;
            tx_data    <= '0;
            ptr        <= '0;
        end else if (adv) begin
            tx_src_rdy <= (n > 0);
            tx_vld     <= nxt_vld;
            tx_data    <= nxt_data;
            if (n > 0) begin
                ptr <= nxt_ptr;
            end
        end
    end

`ifdef MVB_RR_MERGE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_words <= '0;
            stat_items <= '0;
        end else if (tx_src_rdy && tx_dst_rdy) begin
            stat_words <= stat_words + 32'd1;
            stat_items <= stat_items + 32'($countones(tx_vld));
        end
    end
`else
    assign stat_words = '0;
    assign stat_items = '0;
`endif

endmodule
